bayer_to_rgb: RTL and testbench

- AXI4-Stream video demosaic stage for the PCAM RAW10 path.
- Accepts 4 Bayer pixels per beat (GBRG mosaic) and emits 4 RGB pixels per beat.
- Uses a 2x2 nearest-neighbour reconstruction over the current row and the previous row, backed by one line buffer.
- Sits between the camera/CSI unpacker and the VDMA/video pipeline.

---
 rtl/bayer_pkg.sv | 21 ++
 rtl/bayer_line_buffer.sv | 30 +++
 rtl/bayer_to_rgb.sv | 148 ++++++++++++++
 tb/tb_bayer_to_rgb.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bayer_pkg.sv
// Shared types and constants for the GBRG RAW10 demosaic stage.
package bayer_pkg;

    localparam int PIX_W        = 10;
    localparam int PIX_PER_BEAT = 4;

    typedef logic [PIX_W-1:0] raw_pix_t;

    typedef struct packed {
        raw_pix_t r;
        raw_pix_t g;
        raw_pix_t b;
    } rgb_t;

    // Even rows carry G,B,G,B; odd rows carry R,G,R,G.
    typedef enum logic {
        EVEN_GB = 1'b0,
        ODD_RG  = 1'b1
    } phase_t;

endpackage

// File: rtl/bayer_line_buffer.sv
// One-line history RAM: registered read-before-write at the same address.
module bayer_line_buffer
    import bayer_pkg::*;
#(
    parameter int DEPTH = 2048,
    parameter int WIDTH = PIX_PER_BEAT * PIX_W,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // The read samples the old word even when the write hits the same address.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/bayer_to_rgb.sv
// GBRG Bayer to RGB demosaic, 4 pixels per beat, 2x2 nearest-neighbour quads.
module bayer_to_rgb #(
    parameter int MAX_BEATS = 2048,
    parameter int PIX_W     = bayer_pkg::PIX_W
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [4*PIX_W-1:0]  s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                s_axis_tuser,
    input  logic                s_axis_tlast,
    output logic [12*PIX_W-1:0] m_axis_tdata,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic                m_axis_tuser,
    output logic                m_axis_tlast
);
    import bayer_pkg::*;

    localparam int AW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int BW = 4 * PIX_W;
    localparam int OW = 12 * PIX_W;

    // Handshake: a beat moves on either side only when valid and ready are both
    // high at the rising edge; one global stall freezes every stage register
    // while the output beat is held, so s_axis_tready is simply its inverse.
    logic stall;
    logic accept;

    assign stall         = m_axis_tvalid & ~m_axis_tready;
    assign s_axis_tready = ~stall;
    assign accept        = s_axis_tvalid & ~stall;

    phase_t        parity;
    logic          first_row;
    logic [AW-1:0] addr;
    phase_t        cur_parity;
    logic          cur_first;
    logic [AW-1:0] cur_addr;

    // A tuser beat is itself the first beat of row 0.
    always_comb begin
        cur_parity = s_axis_tuser ? EVEN_GB : parity;
        cur_first  = s_axis_tuser | first_row;
        cur_addr   = s_axis_tuser ? '0 : addr;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            parity    <= EVEN_GB;
            first_row <= 1'b1;
            addr      <= '0;
        end else if (accept) begin
            if (s_axis_tlast) begin
                parity    <= (cur_parity == EVEN_GB) ? ODD_RG : EVEN_GB;
                first_row <= 1'b0;
                addr      <= '0;
            end else begin
                parity    <= cur_parity;
                first_row <= cur_first;
                addr      <= (cur_addr == AW'(MAX_BEATS - 1)) ? cur_addr : cur_addr + 1'b1;
            end
        end
    end

    logic [BW-1:0] prev_row;

    bayer_line_buffer #(
        .DEPTH (MAX_BEATS),
        .WIDTH (BW)
    ) u_line_buffer (
        .clk     (aclk),
        .rd_en   (accept),
        .rd_addr (cur_addr),
        .rd_data (prev_row),
        .wr_en   (accept),
        .wr_addr (cur_addr),
        .wr_data (s_axis_tdata)
    );

    logic          s1_valid;
    logic [BW-1:0] s1_data;
    logic          s1_user;
    logic          s1_last;
    phase_t        s1_phase;
    logic          s1_first;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_user  <= 1'b0;
            s1_last  <= 1'b0;
            s1_phase <= EVEN_GB;
            s1_first <= 1'b1;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_data  <= s_axis_tdata;
                s1_user  <= s_axis_tuser;
                s1_last  <= s_axis_tlast;
                s1_phase <= cur_parity;
                s1_first <= cur_first;
            end
        end
    end

    logic [BW-1:0]      companion;
    logic [BW-1:0]      even_row;
    logic [BW-1:0]      odd_row;
    logic [PIX_W:0]     g_sum;
    logic [3*PIX_W-1:0] px;
    logic [OW-1:0]      rgb_beat;

    // Each pixel pair shares one reconstructed colour from its 2x2 quad.
    always_comb begin
        companion = s1_first ? '0 : prev_row;
        even_row  = (s1_phase == EVEN_GB) ? s1_data : companion;
        odd_row   = (s1_phase == EVEN_GB) ? companion : s1_data;
        g_sum     = '0;
        px        = '0;
        rgb_beat  = '0;
        for (int p = 0; p < 2; p++) begin
            g_sum = {1'b0, even_row[2*p*PIX_W +: PIX_W]} + {1'b0, odd_row[(2*p+1)*PIX_W +: PIX_W]};
            px    = {odd_row[2*p*PIX_W +: PIX_W], g_sum[PIX_W:1], even_row[(2*p+1)*PIX_W +: PIX_W]};
            rgb_beat[2*p*3*PIX_W     +: 3*PIX_W] = px;
            rgb_beat[(2*p+1)*3*PIX_W +: 3*PIX_W] = px;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (!stall) begin
            m_axis_tvalid <= s1_valid;
            if (s1_valid) begin
                m_axis_tdata <= rgb_beat;
                m_axis_tuser <= s1_user;
                m_axis_tlast <= s1_last;
            end
        end
    end

endmodule

// File: tb/tb_bayer_to_rgb.sv
// Scoreboard bench for bayer_to_rgb: directed GBRG frames, stalls, gaps and resets.
module tb_bayer_to_rgb;

    localparam int PW = 10;
    localparam int IW = 4 * PW;
    localparam int OW = 12 * PW;
    localparam int EW = OW + 2;

    logic          aclk = 1'b0;
    logic          areset;
    logic [IW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tuser;
    logic          s_axis_tlast;
    logic [OW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tuser;
    logic          m_axis_tlast;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_in     = 0;
    int n_out    = 0;

    logic [EW-1:0] exp_q[$];
    int            lat_q[$];
    bit            lat_en     = 1'b0;
    bit            ready_rand = 1'b0;
    bit            held_v     = 1'b0;
    logic [EW-1:0] held_d;

    bayer_to_rgb dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast)
    );

    // clock / reset block
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            m_axis_tready = ready_rand ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    // Raw beats, {pix3,pix2,pix1,pix0}; even rows G,B,G,B and odd rows R,G,R,G.
    function automatic logic [IW-1:0] mk_data(input int pat, input logic odd);
        logic [IW-1:0] d;
        d = '0;
        case (pat)
            0:       d = odd ? {10'h000, 10'h001, 10'h000, 10'h001} : {10'h000, 10'h000, 10'h000, 10'h000};
            1:       d = odd ? {10'h001, 10'h155, 10'h001, 10'h155} : {10'h200, 10'h3FF, 10'h200, 10'h3FF};
            default: d = odd ? {10'h0FF, 10'h070, 10'h060, 10'h050} : {10'h040, 10'h030, 10'h020, 10'h010};
        endcase
        return d;
    endfunction

    // Hand-computed {R,G,B} per pixel pair for row 0 (companion zero) and later rows.
    function automatic logic [OW-1:0] exp_beat(input int pat, input logic first);
        logic [3*PW-1:0] p0;
        logic [3*PW-1:0] p1;
        case (pat)
            0: begin
                p0 = first ? {10'h000, 10'h000, 10'h000} : {10'h001, 10'h000, 10'h000};
                p1 = p0;
            end
            1: begin
                p0 = first ? {10'h000, 10'h1FF, 10'h200} : {10'h155, 10'h200, 10'h200};
                p1 = p0;
            end
            default: begin
                p0 = first ? {10'h000, 10'h008, 10'h020} : {10'h050, 10'h038, 10'h020};
                p1 = first ? {10'h000, 10'h018, 10'h040} : {10'h070, 10'h097, 10'h040};
            end
        endcase
        return {p1, p1, p0, p0};
    endfunction

    // driver tasks
    task automatic send_beat(input logic [IW-1:0] d, input logic u, input logic l,
                             input logic [EW-1:0] e);
        bit acc;
        acc           = 1'b0;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int w = 0; w < 1000 && !acc; w++) begin
            @(negedge aclk);
            acc = s_axis_tready;
            if (acc) begin
                exp_q.push_back(e);
                if (lat_en) lat_q.push_back(cyc);
                n_in++;
            end
            @(posedge aclk);
            #1;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: s_axis_tready stayed 0, required a beat to be accepted");
        end
    endtask

    task automatic idle();
        s_axis_tvalid = 1'b0;
        @(posedge aclk);
        #1;
    endtask

    task automatic send_row(input int pat, input int row, input int beats, input bit do_last,
                            input int gap);
        logic u;
        logic l;
        for (int b = 0; b < beats; b++) begin
            u = (row == 0) && (b == 0);
            l = do_last && (b == beats - 1);
            send_beat(mk_data(pat, row[0]), u, l, {u, l, exp_beat(pat, row == 0)});
            if (gap > 0 && (b % gap) == gap - 1) idle();
        end
    endtask

    task automatic send_frame(input int pat, input int rows, input int beats, input int gap);
        for (int r = 0; r < rows; r++) send_row(pat, r, beats, 1'b1, gap);
    endtask

    task automatic drain();
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 20000 && exp_q.size() > 0; i++) @(posedge aclk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d beats still outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic do_reset(input int n);
        s_axis_tvalid = 1'b0;
        areset        = 1'b1;
        n_in          = n_in - exp_q.size();
        exp_q.delete();
        lat_q.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            checks++;
            if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata} !== '0 || s_axis_tready !== 1'b1) begin
                failures++;
                $display("FAIL reset_state: valid=%b user=%b last=%b data=%h in_ready=%b, required 0/0/0/0/1",
                         m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata, s_axis_tready);
            end
            @(posedge aclk);
            #1;
        end
        areset = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge aclk) begin
        logic [EW-1:0] e;
        logic [EW-1:0] got;
        int            t0;
        got = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
        if (areset) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || got !== held_d) begin
                    failures++;
                    $display("FAIL stall_stable: valid=%b beat=%h, required 1 and %h", m_axis_tvalid, got, held_d);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                n_out++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat: got %h, required no output", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("FAIL beat: got %h, required %h", got, e);
                    end
                end
                if (lat_en && lat_q.size() > 0) begin
                    t0 = lat_q.pop_front();
                    checks++;
                    if (cyc - t0 != 2) begin
                        failures++;
                        $display("FAIL latency: %0d cycles, required 2", cyc - t0);
                    end
                end
            end
            held_v = m_axis_tvalid && !m_axis_tready;
            held_d = got;
        end
    end

    initial begin
        areset        = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        @(posedge aclk);
        #1;
        do_reset(3);

        send_frame(0, 4, 2048, 0);
        drain();

        send_frame(1, 4, 2048, 0);
        drain();

        ready_rand = 1'b1;
        send_frame(1, 4, 64, 0);
        drain();
        ready_rand = 1'b0;

        lat_en = 1'b1;
        send_frame(1, 4, 64, 3);
        drain();
        lat_en = 1'b0;

        send_row(0, 0, 16, 1'b1, 0);
        send_row(0, 1, 16, 1'b1, 0);
        send_row(0, 2, 5, 1'b0, 0);
        do_reset(3);
        send_frame(0, 2, 16, 0);
        drain();

        send_frame(0, 2, 16, 0);
        send_frame(0, 2, 16, 0);
        drain();

        send_row(2, 0, 16, 1'b1, 0);
        send_row(2, 1, 7, 1'b0, 0);
        send_frame(2, 3, 16, 0);
        drain();

        checks++;
        if (n_out != n_in) begin
            failures++;
            $display("FAIL beat_count: %0d beats out, required %0d", n_out, n_in);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
